// File: rtl/aes_mc_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns engine.
package aes_mc_pkg;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    XFORM,
    DONE
  } mc_state_e;

  // Multiply by x in GF(2^8), reducing modulo AES_POLY.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_lane.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Byte r of the column sits at col_i[31-8r -: 8]; row 0 is the MSB byte.
module mix_column_lane
  import aes_mc_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     enc_dec_i,
  output aes_col_t col_o
);

  logic [7:0] b  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    logic [7:0] enc_byte;
    logic [7:0] dec_byte;

    assign b[r]  = col_i[31-8*r -: 8];
    assign x2[r] = xtime(b[r]);
    assign x4[r] = xtime(x2[r]);
    assign x8[r] = xtime(x4[r]);

    // Row r of the forward matrix: {2,3,1,1} rotated right by r.
    assign enc_byte = x2[r] ^ (x2[R1] ^ b[R1]) ^ b[R2] ^ b[R3];

    // Row r of the inverse matrix: {E,B,D,9} rotated right by r.
    assign dec_byte = (x8[r]  ^ x4[r]  ^ x2[r])
                    ^ (x8[R1] ^ x2[R1] ^ b[R1])
                    ^ (x8[R2] ^ x4[R2] ^ b[R2])
                    ^ (x8[R3] ^ b[R3]);

    assign col_o[31-8*r -: 8] = enc_dec_i ? enc_byte : dec_byte;
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns over a full AES state, LANES
// columns per cycle, with a bypass path for the final cipher round.
//
// state | meaning
// IDLE  | waiting for an input state, in_ready high
// XFORM | transforming LANES columns per cycle in the working register
// DONE  | result valid on out_state, new input accepted when out_ready
module mix_columns_seq
  import aes_mc_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc_dec,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = 4 / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
    $error("mix_columns_seq: LANES must be 1, 2 or 4 (got %0d)", LANES);
  end

  mc_state_e         state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  // Packed so that work_q[3] is column 0 (the MSB word of the state).
  logic [3:0][31:0]  work_q, work_d;
  logic              enc_q, enc_d;
  logic              out_valid_q, busy_q;

  logic [1:0]        col_idx  [LANES];
  aes_col_t          lane_in  [LANES];
  aes_col_t          lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Column handled by this lane in the current step; ~idx maps column
    // number to its packed slot in work_q.
    assign col_idx[l] = 2'(int'(step_q) * LANES + l);
    assign lane_in[l] = work_q[~col_idx[l]];

    mix_column_lane u_lane (
      .col_i     (lane_in[l]),
      .enc_dec_i (enc_q),
      .col_o     (lane_out[l])
    );
  end

  // Next-state, working-register update and input handshake.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    work_d   = work_q;
    enc_d    = enc_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      XFORM: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[~col_idx[l]] = lane_out[l];
        end
        step_d = step_q + 1'b1;
        if (step_q == SW'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides the return to IDLE so DONE can chain without a bubble.
    if (in_valid && in_ready) begin
      work_d  = in_state;
      enc_d   = in_enc_dec;
      step_d  = '0;
      state_d = in_bypass ? DONE : XFORM;
    end
  end

  // State and datapath registers; async reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      work_q      <= '0;
      enc_q       <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      work_q      <= work_d;
      enc_q       <= enc_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == XFORM);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq at LANES = 1, 2 and 4.
module tb_mix_columns_seq;

  typedef struct {
    logic [127:0] st;
    logic         enc;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] exp;
    int           lat;
    int           cyc;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [127:0] in_state   [3];
  logic         in_enc_dec [3];
  logic         in_bypass  [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [127:0] out_state  [3];
  logic         busy       [3];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  sb_t sbq [3][$];
  bit  seen [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mix_columns_seq #(.LANES(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_state   (in_state[g]),
      .in_enc_dec (in_enc_dec[g]),
      .in_bypass  (in_bypass[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_state  (out_state[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] mc_col(input logic [31:0] c, input logic enc);
    logic [7:0] co [4];
    logic [7:0] bb [4];
    logic [7:0] o;
    logic [31:0] res = '0;
    if (enc) begin
      co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
    end else begin
      co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
    end
    for (int j = 0; j < 4; j++) bb[j] = c[31-8*j -: 8];
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int j = 0; j < 4; j++) o ^= gmul(co[(j - r + 4) % 4], bb[j]);
      res[31-8*r -: 8] = o;
    end
    return res;
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] s, input logic enc,
                                            input logic byp);
    logic [127:0] r = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mc_col(s[127-32*c -: 32], enc);
    end
    return r;
  endfunction

  function automatic int lat_of(input int g, input logic byp);
    if (byp) return 1;
    return (g == 0) ? 5 : (g == 1) ? 3 : 2;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output side of the scoreboard: latency on first valid, data on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (out_valid[g]) begin
          if (sbq[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid g=%0d actual=1 required=0", g);
          end else begin
            if (!seen[g]) begin
              seen[g] = 1'b1;
              chk($sformatf("latency g=%0d", g), 128'(cyc - sbq[g][0].cyc),
                  128'(sbq[g][0].lat));
            end
            if (out_ready[g]) begin
              chk($sformatf("out_state g=%0d", g), out_state[g], sbq[g][0].exp);
              void'(sbq[g].pop_front());
              seen[g] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [127:0] st, input logic enc,
                      input logic byp, input logic [127:0] exp);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_state[g]   = st;
    in_enc_dec[g] = enc;
    in_bypass[g]  = byp;
    in_valid[g]   = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[g]) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout g=%0d actual=no_accept required=accept", g);
      in_valid[g] = 1'b0;
    end else begin
      sbq[g].push_back('{exp, lat_of(g, byp), cyc});
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
    end
  endtask

  task automatic drain(input int g);
    for (int i = 0; i < 60 && sbq[g].size() != 0; i++) @(negedge clk);
    if (sbq[g].size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout g=%0d actual=%0d required=0", g, sbq[g].size());
      sbq[g].delete();
      seen[g] = 1'b0;
    end
  endtask

  vec_t vt [8];

  initial begin
    logic [127:0] va, vb, st;
    bit got;

    vt[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vt[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 1'b0,
              128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vt[2] = '{128'hd4d4d4d5_2d26314c_00112233_ffeeddcc, 1'b1, 1'b1,
              128'hd4d4d4d5_2d26314c_00112233_ffeeddcc};
    vt[3] = '{128'hd4d4d4d5_2d26314c_00112233_ffeeddcc, 1'b1, 1'b0,
              {32'hd5d5d7d6, 32'h4d7ebdf8, mc_col(32'h00112233, 1'b1),
               mc_col(32'hffeeddcc, 1'b1)}};
    for (int i = 4; i < 8; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      vt[i] = '{st, 1'(i % 2), 1'(i == 7), mc_state(st, 1'(i % 2), 1'(i == 7))};
    end

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0; in_state[g] = '0; in_enc_dec[g] = 1'b1;
      in_bypass[g] = 1'b0; out_ready[g] = 1'b1; seen[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_out_valid g=%0d", g), 128'(out_valid[g]), 128'(0));
      chk($sformatf("rst_out_state g=%0d", g), out_state[g], 128'(0));
      chk($sformatf("rst_busy g=%0d", g), 128'(busy[g]), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("rst_in_ready g=%0d", g), 128'(in_ready[g]), 128'(1));

    // Table-driven vectors on every lane count.
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 3; g++) begin
        send(g, vt[i].st, vt[i].enc, vt[i].byp, vt[i].exp);
        drain(g);
      end
    end

    // Backpressure then back-to-back accept on LANES=4.
    va = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    vb = 128'hd4d4d4d5_2d26314c_00112233_ffeeddcc;
    out_ready[2] = 1'b0;
    send(2, va, 1'b1, 1'b0, mc_state(va, 1'b1, 1'b0));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (out_valid[2]) got = 1'b1;
      else @(negedge clk);
    end
    chk("bp_valid_seen", 128'(got), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid[2]), 128'(1));
      chk("bp_out_state", out_state[2], mc_state(va, 1'b1, 1'b0));
      chk("bp_in_ready", 128'(in_ready[2]), 128'(0));
    end
    @(posedge clk); #1;
    out_ready[2] = 1'b1;
    in_state[2] = vb; in_enc_dec[2] = 1'b1; in_bypass[2] = 1'b0; in_valid[2] = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 128'(in_ready[2]), 128'(1));
    sbq[2].push_back('{mc_state(vb, 1'b1, 1'b0), 2, cyc});
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    drain(2);

    // Mode latched at accept: flip mode inputs during XFORM on LANES=1.
    send(0, va, 1'b1, 1'b0, mc_state(va, 1'b1, 1'b0));
    in_enc_dec[0] = 1'b0;
    in_bypass[0]  = 1'b1;
    drain(0);
    in_enc_dec[0] = 1'b1;
    in_bypass[0]  = 1'b0;

    // Asynchronous reset at step 2 of a LANES=1 transform.
    send(0, va, 1'b1, 1'b0, mc_state(va, 1'b1, 1'b0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 128'(busy[0]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("arst_out_state", out_state[0], 128'(0));
    chk("arst_busy", 128'(busy[0]), 128'(0));
    sbq[0].delete();
    seen[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready[0]), 128'(1));
    send(0, vb, 1'b0, 1'b0, mc_state(vb, 1'b0, 1'b0));
    drain(0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, parametrised MixColumns / InvMixColumns engine for a full 128-bit AES state (four columns).
- Processes LANES columns per cycle, so area can be traded against latency.
- Uses a valid/ready handshake on both input and output, and includes a bypass mode for the final cipher round.
- Sits between ShiftRows and AddRoundKey in the iterative cipher datapath.

Parameters:
- LANES, 4, columns transformed per cycle. Legal values are 1, 2, 4; any other value is an elaboration-time $error.
- STEPS, 4/LANES (localparam), cycles needed per state.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state is valid.
- in_ready  out  1  block can accept a state this cycle.
- in_state  in  128  input state; column c = in_state[127-32c -: 32]; MSB byte = row 0.
- in_enc_dec  in  1  1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt).
- in_bypass  in  1  1 = pass state through unchanged (final round).
- out_valid  out  1  out_state holds a finished result.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  transformed state, same column/byte ordering as in_state.
- busy  out  1  high in XFORM state.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst_n.
  - state = IDLE, step counter = 0, out_valid = 0, out_state = 0, busy = 0.
  - An in-flight operation is discarded.
  - in_ready = 1 after reset release.
- FSM states:
  - IDLE: in_ready = 1.
  - XFORM: in_ready = 0, busy = 1.
  - DONE: out_valid = 1; in_ready = out_ready.
- Accept: when in_valid && in_ready, latch in_state into the working register, latch mode (in_enc_dec, in_bypass) and clear the counter.
  - Mode is held for the whole operation; later changes on mode inputs are ignored until the next accept.
- Accept with in_bypass = 1: the working register is loaded unchanged and the FSM goes directly to DONE. out_valid rises on the next cycle (latency 1), independent of LANES.
- Accept with in_bypass = 0: the FSM goes to XFORM.
  - Each XFORM cycle replaces columns step*LANES .. step*LANES+LANES-1 of the working register in place with their transformed values, then increments step.
  - After the step = STEPS-1 update, the FSM goes to DONE.
  - Latency from the accept edge to out_valid = STEPS+1 cycles: LANES=4 gives 2, LANES=2 gives 3, LANES=1 gives 5.
- DONE:
  - out_state and out_valid are held stable while out_ready = 0.
  - If out_ready = 1 and in_valid = 0, the FSM returns to IDLE; out_valid = 0 next cycle.
  - Simultaneous out_ready && in_valid in DONE: the output handshake completes and the new state is accepted in the same cycle, with no bubble. Next state is XFORM, or DONE for a bypass.
- Arithmetic, GF(2^8) with polynomial 0x11B:
  - Encrypt matrix rows: {2,3,1,1} rotated per row.
  - Decrypt matrix rows: {E,B,D,9} rotated per row.
  - Multiples are built from xtime chains: x2, x4, x8.
- Outputs are registered; there are no combinational paths from in_* to out_*.
- in_ready is a function of FSM state and out_ready only.
- in_valid dropping while in_ready = 0 is legal and has no effect.

Decomposition:
- Package aes_mc_pkg:
  - function xtime(byte), GF(2^8) doubling;
  - typedef aes_col_t (logic [31:0]) and aes_state_t (logic [127:0]);
  - typedef enum mc_state_e {IDLE, XFORM, DONE};
  - localparam AES_POLY = 8'h1B.
- Sub-module mix_column_lane: combinational single-column enc/dec transform, column in, column out, enc_dec select. It is instantiated LANES times through a generate loop. Column selection uses a step-indexed mux.

Test Plan:
- Encrypt, LANES=4: in_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6, enc_dec = 1 -> out_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 2 cycles after accept.
- Decrypt, LANES=1: in_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, enc_dec = 0 -> out_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6, out_valid 5 cycles after accept. Repeat at LANES=2 with latency 3.
- Bypass: in_bypass = 1, in_state = 128'hd4d4d4d5_2d26314c_00112233_ffeeddcc -> identical out_state 1 cycle after accept. Also check enc d4d4d4d5 -> d5d5d7d6 and 2d26314c -> 4d7ebdf8 with bypass = 0.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 10 cycles -> out_state and out_valid stable, in_ready = 0.
  - Then assert out_ready with in_valid = 1 -> result consumed and next state accepted in the same cycle. The second result is correct with no idle cycle.
- Reset mid-XFORM, LANES=1: assert rst_n = 0 at step 2 -> out_valid = 0, out_state = 0, busy = 0 immediately (asynchronous). After release, in_ready = 1 and a new state processes correctly.
- Mode latch: change in_enc_dec during XFORM -> result follows the mode latched at accept.
